melody_sequencer: RTL and testbench

//  Programmable note sequencer: successor to the fixed 20-note tune player.

---
 rtl/melody_sequencer.sv | 170 +++++++++++++++++
 tb/tb_melody_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/melody_sequencer.sv
// Programmable note sequencer: a writable note table played at an internal fs tick, with looping, rests and stop.
// Optional articulation gap (note_valid low for the final GAP_TICKS ticks) is enabled by defining SEQ_GAP_EN.
module melody_sequencer #(
    parameter int DEPTH     = 32,
    parameter int PITCH_W   = 5,
    parameter int DUR_W     = 13,
    parameter int FS_DIV    = 125,
    parameter int FS_W      = 7,
    parameter int GAP_TICKS = 200,
    parameter int IW        = $clog2(DEPTH)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               wr_en_i,
    input  logic [IW-1:0]      wr_addr_i,
    input  logic [PITCH_W-1:0] wr_pitch_i,
    input  logic [DUR_W-1:0]   wr_dur_i,
    input  logic [IW-1:0]      last_idx_i,
    input  logic               loop_en_i,
    input  logic               start_i,
    input  logic               stop_i,
    output logic               busy_o,
    output logic [IW-1:0]      note_idx_o,
    output logic [PITCH_W-1:0] pitch_maxval_o,
    output logic               note_valid_o,
    output logic               note_start_o,
    output logic               done_o,
    output logic               state_o
);
    typedef enum logic {S_IDLE = 1'b0, S_PLAY = 1'b1} state_e;

    // Handshake: start_i/stop_i are single-cycle requests sampled every clock; stop wins over start,
    // and start is ignored while playing. Outputs are all registered.

    logic [PITCH_W+DUR_W-1:0] mem_q [DEPTH];

    state_e               state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [IW-1:0]        last_q, last_d;
    logic [PITCH_W-1:0]   pitch_q, pitch_d;
    logic [DUR_W-1:0]     dur_q, dur_d;
    logic [DUR_W-1:0]     dur_cnt_q, dur_cnt_d;
    logic [FS_W-1:0]      fs_cnt_q, fs_cnt_d;
    logic                 busy_q, busy_d;
    logic                 valid_q, valid_d;
    logic                 note_start_q, note_start_d;
    logic                 done_q, done_d;
    logic                 load;
    logic [IW-1:0]        load_idx;
    logic                 tick;
    logic                 in_gap;
    logic [PITCH_W+DUR_W-1:0] rd_entry;
    logic [DUR_W-1:0]     rd_dur;

    // Non-blocking write: a load of the same entry in this cycle still sees the old contents.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) mem_q[wr_addr_i] <= {wr_pitch_i, wr_dur_i};
    end

    assign rd_entry = mem_q[load_idx];
    assign rd_dur   = rd_entry[DUR_W-1:0];
    assign tick     = (fs_cnt_q == FS_W'(FS_DIV - 1));

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        last_d       = last_q;
        pitch_d      = pitch_q;
        dur_d        = dur_q;
        dur_cnt_d    = dur_cnt_q;
        fs_cnt_d     = fs_cnt_q;
        note_start_d = 1'b0;
        done_d       = 1'b0;
        load         = 1'b0;
        load_idx     = '0;
        case (state_q)
            S_IDLE: begin
                if (start_i && !stop_i) begin
                    state_d  = S_PLAY;
                    last_d   = last_idx_i;
                    load     = 1'b1;
                    load_idx = '0;
                end
            end
            S_PLAY: begin
                if (stop_i) begin
                    state_d   = S_IDLE;
                    pitch_d   = '0;
                    fs_cnt_d  = '0;
                    dur_cnt_d = '0;
                end else begin
                    fs_cnt_d = tick ? '0 : fs_cnt_q + FS_W'(1);
                    if (tick) begin
                        if (dur_cnt_q == dur_q - DUR_W'(1)) begin
                            if (idx_q < last_q) begin
                                load     = 1'b1;
                                load_idx = idx_q + IW'(1);
                            end else if (loop_en_i) begin
                                load     = 1'b1;
                                load_idx = '0;
                            end else begin
                                state_d   = S_IDLE;
                                pitch_d   = '0;
                                fs_cnt_d  = '0;
                                dur_cnt_d = '0;
                                done_d    = 1'b1;
                            end
                        end else begin
                            dur_cnt_d = dur_cnt_q + DUR_W'(1);
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (load) begin
            idx_d        = load_idx;
            pitch_d      = rd_entry[PITCH_W+DUR_W-1:DUR_W];
            dur_d        = (rd_dur == '0) ? DUR_W'(1) : rd_dur;
            fs_cnt_d     = '0;
            dur_cnt_d    = '0;
            note_start_d = 1'b1;
        end
        busy_d  = (state_d == S_PLAY);
        valid_d = busy_d && (pitch_d != '0) && !in_gap;
    end

`ifdef SEQ_GAP_EN
    // Gap covers the final GAP_TICKS tick periods of long notes; evaluated on next-state counters.
    assign in_gap = (dur_d > DUR_W'(GAP_TICKS)) && (dur_cnt_d >= dur_d - DUR_W'(GAP_TICKS));
`else
    assign in_gap = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            last_q       <= '0;
            pitch_q      <= '0;
            dur_q        <= '0;
            dur_cnt_q    <= '0;
            fs_cnt_q     <= '0;
            busy_q       <= 1'b0;
            valid_q      <= 1'b0;
            note_start_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            last_q       <= last_d;
            pitch_q      <= pitch_d;
            dur_q        <= dur_d;
            dur_cnt_q    <= dur_cnt_d;
            fs_cnt_q     <= fs_cnt_d;
            busy_q       <= busy_d;
            valid_q      <= valid_d;
            note_start_q <= note_start_d;
            done_q       <= done_d;
        end
    end

    assign busy_o         = busy_q;
    assign note_idx_o     = idx_q;
    assign pitch_maxval_o = pitch_q;
    assign note_valid_o   = valid_q;
    assign note_start_o   = note_start_q;
    assign done_o         = done_q;
    assign state_o        = state_q;
endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: directed scenarios plus random tables, checked per cycle against a trace model.
// The model expands the note table into an expected output sequence; SEQ_GAP_EN selects gap expectations.
module tb_melody_sequencer;
    localparam int FS  = 4;
    localparam int GAP = 1;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        wr_en_i = 1'b0;
    logic [2:0]  wr_addr_i = '0;
    logic [4:0]  wr_pitch_i = '0;
    logic [12:0] wr_dur_i = '0;
    logic [2:0]  last_idx_i = '0;
    logic        loop_en_i = 1'b0;
    logic        start_i = 1'b0;
    logic        stop_i = 1'b0;
    logic        busy_o, note_valid_o, note_start_o, done_o, state_o;
    logic [2:0]  note_idx_o;
    logic [4:0]  pitch_maxval_o;

    melody_sequencer #(.DEPTH(8), .FS_DIV(FS), .GAP_TICKS(GAP)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
        .wr_pitch_i(wr_pitch_i), .wr_dur_i(wr_dur_i), .last_idx_i(last_idx_i),
        .loop_en_i(loop_en_i), .start_i(start_i), .stop_i(stop_i), .busy_o(busy_o),
        .note_idx_o(note_idx_o), .pitch_maxval_o(pitch_maxval_o), .note_valid_o(note_valid_o),
        .note_start_o(note_start_o), .done_o(done_o), .state_o(state_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad = 0;
    int tb_pitch [8];
    int tb_dur [8];
    int tb_last;
    bit tb_loop;
    logic [11:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [11:0] pack(input bit b, input int i, input int p,
                                         input bit v, input bit ns, input bit dn);
        logic [2:0] i3;
        logic [4:0] p5;
        i3 = i[2:0];
        p5 = p[4:0];
        return {b, i3, p5, v, ns, dn};
    endfunction

    function automatic logic [11:0] obs();
        return {busy_o, note_idx_o, pitch_maxval_o, note_valid_o, note_start_o, done_o};
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic write_entry(input int a, input int p, input int d);
        wr_en_i = 1'b1;
        wr_addr_i = a[2:0];
        wr_pitch_i = p[4:0];
        wr_dur_i = d[12:0];
        step();
        wr_en_i = 1'b0;
        tb_pitch[a] = p;
        tb_dur[a] = d;
    endtask

    // Expected trace from start+1: one entry per cycle; stop_at is the trace index where stop is held.
    task automatic build_exp(input int stop_at);
        int i;
        int d;
        bit fin;
        bit v;
        i = 0;
        fin = 0;
        exp_q.delete();
        while (!fin) begin
            d = (tb_dur[i] == 0) ? 1 : tb_dur[i];
            for (int c = 0; c < d * FS && !fin; c++) begin
                v = (tb_pitch[i] != 0);
`ifdef SEQ_GAP_EN
                if (d > GAP && c >= (d - GAP) * FS) v = 0;
`endif
                exp_q.push_back(pack(1, i, tb_pitch[i], v, c == 0, 0));
                if (exp_q.size() - 1 == stop_at) begin
                    exp_q.push_back(pack(0, i, 0, 0, 0, 0));
                    fin = 1;
                end
            end
            if (!fin) begin
                if (i < tb_last) i++;
                else if (tb_loop) i = 0;
                else begin
                    exp_q.push_back(pack(0, i, 0, 0, 0, 1));
                    exp_q.push_back(pack(0, i, 0, 0, 0, 0));
                    fin = 1;
                end
            end
        end
    endtask

    task automatic run_trace(input int stop_at, input bit rnd_start, input string tag);
        last_idx_i = tb_last[2:0];
        loop_en_i = tb_loop;
        build_exp(stop_at);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int k = 0; k < exp_q.size(); k++) begin
            check_eq(tag, {20'd0, obs()}, {20'd0, exp_q[k]});
            if (k == stop_at) stop_i = 1'b1;
            else if (rnd_start && exp_q[k][11] && k + 1 < exp_q.size() && exp_q[k+1][11]
                     && $urandom_range(0, 3) == 0) start_i = 1'b1;
            step();
            start_i = 1'b0;
            stop_i = 1'b0;
        end
    endtask

    task automatic load_tune1();
        write_entry(0, 18, 2);
        write_entry(1, 13, 1);
        write_entry(2, 0, 3);
        tb_last = 2;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            tb_pitch[i] = 0;
            tb_dur[i] = 0;
        end
        tb_last = 0;
        tb_loop = 0;
        step();
        step();
        check_eq("reset_outputs", {20'd0, obs()}, 32'd0);
        check_eq("reset_state", {31'd0, state_o}, 32'd0);
        rst_ni = 1'b1;
        step();
        for (int i = 0; i < 8; i++) write_entry(i, 0, 1);

        load_tune1();
        tb_loop = 0;
        run_trace(-1, 0, "tune_once");

        tb_loop = 1;
        run_trace(30, 0, "tune_loop");

        tb_loop = 0;
        run_trace(4, 0, "stop_note0");

        start_i = 1'b1;
        stop_i = 1'b1;
        step();
        start_i = 1'b0;
        stop_i = 1'b0;
        check_eq("startstop_busy", {31'd0, busy_o}, 32'd0);
        check_eq("startstop_ns", {31'd0, note_start_o}, 32'd0);
        step();
        check_eq("startstop_idle", {31'd0, state_o}, 32'd0);

        write_entry(0, 20, 0);
        tb_last = 0;
        tb_loop = 0;
        run_trace(-1, 1, "dur_zero");

        load_tune1();
        last_idx_i = 3'd2;
        loop_en_i = 1'b0;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        step();
        step();
        #2;
        rst_ni = 1'b0;
        #1;
        check_eq("async_reset_out", {20'd0, obs()}, 32'd0);
        check_eq("async_reset_state", {31'd0, state_o}, 32'd0);
        step();
        rst_ni = 1'b1;
        step();
        load_tune1();
        run_trace(-1, 0, "after_reset");

        write_entry(0, 18, 3);
        tb_last = 0;
        tb_loop = 0;
        run_trace(-1, 0, "gap_note");

        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < 8; i++)
                write_entry(i, ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 31),
                            $urandom_range(0, 3));
            tb_last = $urandom_range(0, 7);
            tb_loop = $urandom_range(0, 1);
            if (tb_loop) run_trace($urandom_range(0, 80), 1, "rand_loop");
            else run_trace(($urandom_range(0, 1) == 1) ? $urandom_range(0, 40) : -1, 1, "rand_once");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
